// File: rtl/booth_mult_sequencer_if.sv
// rtl/booth_mult_sequencer_if.sv - operand, core and result buses of the booth multiplier sequencer
interface booth_mult_sequencer_if #(
    parameter int W = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_multiplicand;
    logic [W-1:0]   in_multiplier;
    logic           mul_load;
    logic [W-1:0]   mul_multiplicand;
    logic [W-1:0]   mul_multiplier;
    logic [2*W-1:0] mul_product;
    logic           mul_done;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_product;
    logic           out_error;
    logic           busy;

    modport slave (
        input  in_valid, in_multiplicand, in_multiplier, mul_product, mul_done, out_ready,
        output in_ready, mul_load, mul_multiplicand, mul_multiplier,
               out_valid, out_product, out_error, busy
    );

    modport master (
        output in_valid, in_multiplicand, in_multiplier, mul_product, mul_done, out_ready,
        input  in_ready, mul_load, mul_multiplicand, mul_multiplier,
               out_valid, out_product, out_error, busy
    );
endinterface

// File: rtl/booth_mult_sequencer.sv
// rtl/booth_mult_sequencer.sv - operand FIFO, core load/wait sequencing and result hold for a booth multiplier core
module booth_mult_sequencer #(
    parameter int W           = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int TIMEOUT     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    booth_mult_sequencer_if.slave bus
);
    localparam int LW = $clog2(LOAD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [1:0][2*W-1:0] fifo_q, fifo_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [W-1:0]        op_m_q, op_m_d;
    logic [W-1:0]        op_r_q, op_r_d;
    logic [LW-1:0]       load_cnt_q, load_cnt_d;
    logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [2*W-1:0]      prod_q, prod_d;
    logic                err_q, err_d;
    logic                push, pop;

    assign push = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        op_m_d     = op_m_q;
        op_r_d     = op_r_q;
        load_cnt_d = load_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        prod_d     = prod_q;
        err_d      = err_q;
        pop        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != 2'd0) begin
                    pop        = 1'b1;
                    op_m_d     = fifo_q[rd_ptr_q][2*W-1:W];
                    op_r_d     = fifo_q[rd_ptr_q][W-1:0];
                    load_cnt_d = LW'(LOAD_CYCLES);
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                load_cnt_d = load_cnt_q - LW'(1);
                if (load_cnt_q == LW'(1)) begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (bus.mul_done) begin
                    prod_d  = bus.mul_product;
                    err_d   = 1'b0;
                    state_d = S_HOLD;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = {bus.in_multiplicand, bus.in_multiplier};
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fifo_q     <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            op_m_q     <= '0;
            op_r_q     <= '0;
            load_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            prod_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            op_m_q     <= op_m_d;
            op_r_q     <= op_r_d;
            load_cnt_q <= load_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            prod_q     <= prod_d;
            err_q      <= err_d;
        end
    end

    // the core is held cleared whenever it is not being waited on, including during reset
    assign bus.in_ready         = !reset && (count_q != 2'd2);
    assign bus.mul_load         = reset || (state_q != S_WAIT);
    assign bus.mul_multiplicand = op_m_q;
    assign bus.mul_multiplier   = op_r_q;
    assign bus.out_valid        = (state_q == S_HOLD);
    assign bus.out_product      = prod_q;
    assign bus.out_error        = err_q;
    assign bus.busy             = (state_q != S_IDLE) || (count_q != 2'd0);
endmodule
